data_memory: RTL and testbench
==============================

Name: data_memory

Overview:
Data-memory responder for the pipelined processor's MEM-stage interface. Serves byte, halfword and word loads and stores on MemAddr/DataMemIn/DataMemOut/MemRead/MemWrite. Stores pass through a one-entry store buffer with store-to-load forwarding. A small memory-mapped status/counter window completes the block.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words in the array (power of two)
ADDR_W, log2(DEPTH_WORDS), word-index width (derived, not overridden)
MMIO_BASE, 32'hFFFF_0000, base of the 16-byte status window (16-byte aligned)

Ports:
Clk  in  1  clock, all state on rising edge
Rst  in  1  reset, asynchronous, active-low
MemAddr  in  32  byte address from processor
DataMemIn  in  32  store data, right-justified (byte in [7:0], half in [15:0])
MemRead  in  2  load size: 00 none, 01 byte, 10 half, 11 word
MemWrite  in  2  store size, same encoding
DataMemOut  out  32  load data, combinational, same cycle as request
AlignErr  out  1  sticky misalignment/conflict flag
ErrAddr  out  32  address of first error since last clear
CycleCount  out  32  free-running clock counter
StoreCount  out  32  accepted-store counter

Behaviour:
- Little-endian: byte at addr[1:0]=0 is bits [7:0]. Word index = MemAddr[ADDR_W+1:2]; higher bits alias, except the MMIO window.
- MMIO hit: MemAddr[31:4]==MMIO_BASE[31:4]. Offset 0 = CycleCount (RO), 4 = StoreCount (RO), 8 = {31'b0,AlignErr}, any store to offset 8 clears AlignErr and ErrAddr. MMIO stores never enter the buffer or bump StoreCount. MMIO loads ignore size and return the full word.
- Loads: DataMemOut is combinational. Byte/half results are sign-extended. MemRead=00 -> DataMemOut=0.
- Store buffer (pend_valid, pend_idx, pend_be[3:0], pend_data):
  - An aligned store in cycle N is captured at the edge ending N with lane-shifted data and byte enables.
  - The buffered store commits to the array at the edge ending N+1.
  - A new store in N+1 overwrites the buffer in the same edge that commits the old entry.
- Forwarding: if pend_valid and pend_idx matches the load word index, enabled bytes come from pend_data and the rest from the array. Back-to-back store/load to the same address returns the new data, zero wait.
- Misaligned access (half with addr[0]=1; word with addr[1:0]!=0) or MemRead!=00 with MemWrite!=00 in the same cycle:
  - Access suppressed: no buffer capture, DataMemOut=0.
  - AlignErr set at that edge.
  - ErrAddr captures MemAddr only if AlignErr was 0 (first-error hold).
  - A clear and a new error in the same cycle: the error wins.
- CycleCount: +1 every edge out of reset, wraps 2^32-1 -> 0. StoreCount: +1 per accepted non-MMIO store, wraps.
- Reset (async assert, any time): pend_valid=0, all counters 0, AlignErr=0, ErrAddr=0. DataMemOut follows inputs (0 when idle). A pending store at reset is discarded. Array contents are not reset (undefined).
- Latency: load 0 cycles; store visible to loads next cycle via forwarding, in the array 2 edges later.

Decomposition:
- Package mem_defs:
  - Size encodings SZ_NONE/SZ_BYTE/SZ_HALF/SZ_WORD.
  - MMIO offsets OFF_CYCLE=0, OFF_STORES=4, OFF_STATUS=8.
  - Function for size+addr -> byte-enable/alignment check.
- Sub-module store_buffer: pending register, commit strobe, byte-merge forwarding mux. The top keeps the array, MMIO decode, counters and error logic.

Test Plan:
- Reset low mid-store -> after release, load of that word returns the prior value. CycleCount=0, StoreCount=0, AlignErr=0.
- Word store 0x1234_5678 @0x40, next cycle byte load @0x43 -> DataMemOut=0x0000_0012 (forwarded). 3 cycles later word load @0x40 -> 0x1234_5678 from array.
- Byte store 0xF0 @0x41 onto word 0xAABB_CCDD, then half load @0x40 -> 0xFFFF_F0DD (merge plus sign extension). StoreCount increments by 1.
- Word load @0x42 -> DataMemOut=0, AlignErr=1, ErrAddr=0x42. Then half store @0x11 -> ErrAddr stays 0x42. Store to 0xFFFF_0008 -> AlignErr=0, ErrAddr=0.
- Load 0xFFFF_0000 at k cycles after reset -> returns k. Store to 0xFFFF_0004 -> StoreCount unchanged.
- MemRead=11 and MemWrite=11 together @0x80 -> no array change, DataMemOut=0, AlignErr=1.

Source files
------------

// File: rtl/data_memory_pkg.sv
// ----------------------------------------------------------------------------
// mem_defs : access-size encodings, MMIO offsets and the lane/alignment helper
// Revision : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package mem_defs;

  localparam logic [1:0] SZ_NONE = 2'b00;
  localparam logic [1:0] SZ_BYTE = 2'b01;
  localparam logic [1:0] SZ_HALF = 2'b10;
  localparam logic [1:0] SZ_WORD = 2'b11;

  localparam logic [3:0] OFF_CYCLE  = 4'h0;
  localparam logic [3:0] OFF_STORES = 4'h4;
  localparam logic [3:0] OFF_STATUS = 4'h8;

  typedef struct packed {
    logic       ok;
    logic [3:0] be;
  } lane_t;

  // Byte enables for a size/offset pair; misaligned accesses get no enables.
  function automatic lane_t lane_decode(input logic [1:0] size, input logic [1:0] off);
    lane_t r;
    r.ok = 1'b1;
    r.be = 4'b0000;
    case (size)
      SZ_BYTE: r.be = 4'b0001 << off;
      SZ_HALF: begin
        r.ok = ~off[0];
        r.be = r.ok ? (4'b0011 << off) : 4'b0000;
      end
      SZ_WORD: begin
        r.ok = (off == 2'b00);
        r.be = r.ok ? 4'b1111 : 4'b0000;
      end
      default: ;
    endcase
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/data_memory_store_buffer.sv
// ----------------------------------------------------------------------------
// store_buffer : one-entry pending store with commit strobe and byte-merge
//                forwarding of the pending bytes over the array read word.
// Revision     : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module store_buffer #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_idx,
  input  logic [3:0]        i_wr_be,
  input  logic [31:0]       i_wr_data,
  input  logic [ADDR_W-1:0] i_rd_idx,
  input  logic [31:0]       i_rd_array,
  output logic              o_commit_en,
  output logic [ADDR_W-1:0] o_commit_idx,
  output logic [3:0]        o_commit_be,
  output logic [31:0]       o_commit_data,
  output logic [31:0]       o_rd_word
);

  logic              pend_valid_q, pend_valid_d;
  logic [ADDR_W-1:0] pend_idx_q,   pend_idx_d;
  logic [3:0]        pend_be_q,    pend_be_d;
  logic [31:0]       pend_data_q,  pend_data_d;
  logic              w_hit;

  // The entry always drains on the next edge, so a new store simply replaces it.
  always_comb begin
    pend_valid_d = i_wr_en;
    pend_idx_d   = i_wr_en ? i_wr_idx  : pend_idx_q;
    pend_be_d    = i_wr_en ? i_wr_be   : pend_be_q;
    pend_data_d  = i_wr_en ? i_wr_data : pend_data_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_valid_q <= 1'b0;
      pend_idx_q   <= '0;
      pend_be_q    <= 4'b0000;
      pend_data_q  <= 32'h0;
    end else begin
      pend_valid_q <= pend_valid_d;
      pend_idx_q   <= pend_idx_d;
      pend_be_q    <= pend_be_d;
      pend_data_q  <= pend_data_d;
    end
  end

  assign o_commit_en   = pend_valid_q;
  assign o_commit_idx  = pend_idx_q;
  assign o_commit_be   = pend_be_q;
  assign o_commit_data = pend_data_q;

  assign w_hit = pend_valid_q && (pend_idx_q == i_rd_idx);

  always_comb begin
    o_rd_word = i_rd_array;
    for (int b = 0; b < 4; b++) begin
      if (w_hit && pend_be_q[b]) o_rd_word[b*8 +: 8] = pend_data_q[b*8 +: 8];
    end
  end

endmodule

`default_nettype wire

// File: rtl/data_memory.sv
// ----------------------------------------------------------------------------
// data_memory : MEM-stage data memory with store buffer, forwarding, MMIO
//               status/counter window and sticky alignment-error capture.
// Revision    : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module data_memory
  import mem_defs::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [31:0] MemAddr,
  input  logic [31:0] DataMemIn,
  input  logic [1:0]  MemRead,
  input  logic [1:0]  MemWrite,
  output logic [31:0] DataMemOut,
  output logic        AlignErr,
  output logic [31:0] ErrAddr,
  output logic [31:0] CycleCount,
  output logic [31:0] StoreCount
);

  localparam int ADDR_W = $clog2(DEPTH_WORDS);

  logic [31:0]       mem_array [DEPTH_WORDS];

  logic              align_err_q,   align_err_d;
  logic [31:0]       err_addr_q,    err_addr_d;
  logic [31:0]       cycle_count_q, cycle_count_d;
  logic [31:0]       store_count_q, store_count_d;

  logic [ADDR_W-1:0] w_idx;
  logic              w_mmio_hit;
  lane_t             w_rd_lane;
  lane_t             w_wr_lane;
  logic              w_err;
  logic              w_store_accept;
  logic              w_status_clear;
  logic [31:0]       w_wr_data;
  logic [31:0]       w_fwd_word;
  logic [31:0]       w_lane_word;
  logic              w_commit_en;
  logic [ADDR_W-1:0] w_commit_idx;
  logic [3:0]        w_commit_be;
  logic [31:0]       w_commit_data;

  assign w_idx      = MemAddr[ADDR_W+1:2];
  assign w_mmio_hit = (MemAddr[31:4] == MMIO_BASE[31:4]);
  assign w_rd_lane  = lane_decode(MemRead,  MemAddr[1:0]);
  assign w_wr_lane  = lane_decode(MemWrite, MemAddr[1:0]);

  // A simultaneous load and store is treated like a misalignment.
  assign w_err = ((MemRead != SZ_NONE) && (MemWrite != SZ_NONE))
               || !w_rd_lane.ok || !w_wr_lane.ok;

  assign w_store_accept = (MemWrite != SZ_NONE) && !w_err && !w_mmio_hit;
  assign w_status_clear = (MemWrite != SZ_NONE) && !w_err && w_mmio_hit
                        && (MemAddr[3:2] == OFF_STATUS[3:2]);
  assign w_wr_data      = DataMemIn << {MemAddr[1:0], 3'b000};

  store_buffer #(.ADDR_W(ADDR_W)) u_store_buffer (
    .clk           (Clk),
    .rst_n         (Rst),
    .i_wr_en       (w_store_accept),
    .i_wr_idx      (w_idx),
    .i_wr_be       (w_wr_lane.be),
    .i_wr_data     (w_wr_data),
    .i_rd_idx      (w_idx),
    .i_rd_array    (mem_array[w_idx]),
    .o_commit_en   (w_commit_en),
    .o_commit_idx  (w_commit_idx),
    .o_commit_be   (w_commit_be),
    .o_commit_data (w_commit_data),
    .o_rd_word     (w_fwd_word)
  );

  always_ff @(posedge Clk) begin
    if (w_commit_en) begin
      for (int b = 0; b < 4; b++) begin
        if (w_commit_be[b]) mem_array[w_commit_idx][b*8 +: 8] <= w_commit_data[b*8 +: 8];
      end
    end
  end

  // An error in the same cycle as a clear leaves the flag set.
  always_comb begin
    align_err_d   = align_err_q;
    err_addr_d    = err_addr_q;
    cycle_count_d = cycle_count_q + 32'd1;
    store_count_d = store_count_q + {31'b0, w_store_accept};
    if (w_status_clear) begin
      align_err_d = 1'b0;
      err_addr_d  = 32'h0;
    end
    if (w_err) begin
      align_err_d = 1'b1;
      if (!align_err_q) err_addr_d = MemAddr;
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      align_err_q   <= 1'b0;
      err_addr_q    <= 32'h0;
      cycle_count_q <= 32'h0;
      store_count_q <= 32'h0;
    end else begin
      align_err_q   <= align_err_d;
      err_addr_q    <= err_addr_d;
      cycle_count_q <= cycle_count_d;
      store_count_q <= store_count_d;
    end
  end

  assign w_lane_word = w_fwd_word >> {MemAddr[1:0], 3'b000};

  always_comb begin
    DataMemOut = 32'h0;
    if ((MemRead != SZ_NONE) && !w_err) begin
      if (w_mmio_hit) begin
        case (MemAddr[3:2])
          OFF_CYCLE[3:2]:  DataMemOut = cycle_count_q;
          OFF_STORES[3:2]: DataMemOut = store_count_q;
          OFF_STATUS[3:2]: DataMemOut = {31'b0, align_err_q};
          default:         DataMemOut = 32'h0;
        endcase
      end else begin
        case (MemRead)
          SZ_BYTE: DataMemOut = {{24{w_lane_word[7]}},  w_lane_word[7:0]};
          SZ_HALF: DataMemOut = {{16{w_lane_word[15]}}, w_lane_word[15:0]};
          default: DataMemOut = w_lane_word;
        endcase
      end
    end
  end

  assign AlignErr   = align_err_q;
  assign ErrAddr    = err_addr_q;
  assign CycleCount = cycle_count_q;
  assign StoreCount = store_count_q;

endmodule

`default_nettype wire

// File: tb/tb_data_memory.sv
// ----------------------------------------------------------------------------
// tb_data_memory : directed self-checking bench for data_memory
// Revision       : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_data_memory;

  logic        Clk;
  logic        Rst;
  logic [31:0] MemAddr;
  logic [31:0] DataMemIn;
  logic [1:0]  MemRead;
  logic [1:0]  MemWrite;
  logic [31:0] DataMemOut;
  logic        AlignErr;
  logic [31:0] ErrAddr;
  logic [31:0] CycleCount;
  logic [31:0] StoreCount;

  int checks   = 0;
  int failures = 0;
  int k        = 0;

  data_memory dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .MemAddr    (MemAddr),
    .DataMemIn  (DataMemIn),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .DataMemOut (DataMemOut),
    .AlignErr   (AlignErr),
    .ErrAddr    (ErrAddr),
    .CycleCount (CycleCount),
    .StoreCount (StoreCount)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // k tracks rising edges seen since the last reset release.
  task automatic tick();
    @(posedge Clk);
    #1;
    if (!Rst) k = 0;
    else      k = k + 1;
  endtask

  task automatic drive(input logic [1:0] rd, input logic [1:0] wr,
                       input logic [31:0] addr, input logic [31:0] data);
    MemRead   = rd;
    MemWrite  = wr;
    MemAddr   = addr;
    DataMemIn = data;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    Rst = 1'b0;
    drive(2'b00, 2'b00, 32'h0, 32'h0);
    tick(); tick();
    Rst = 1'b1;
    k = 0;

    // Establish a prior value at 0x20, then reset with a newer store pending.
    drive(2'b00, 2'b11, 32'h20, 32'hCAFE_F00D); tick();
    drive(2'b00, 2'b00, 32'h0, 32'h0); tick(); tick(); tick();
    drive(2'b00, 2'b11, 32'h20, 32'hDEAD_BEEF); tick();
    drive(2'b00, 2'b00, 32'h0, 32'h0);
    #1 Rst = 1'b0;
    tick();
    Rst = 1'b1;
    k = 0;

    drive(2'b11, 2'b00, 32'h20, 32'h0);
    @(negedge Clk);
    check("rst_discard_pending", DataMemOut, 32'hCAFE_F00D);
    check("rst_cycle", CycleCount, 32'h0);
    check("rst_stores", StoreCount, 32'h0);
    check("rst_alignerr", {31'b0, AlignErr}, 32'h0);
    check("rst_erraddr", ErrAddr, 32'h0);
    drive(2'b00, 2'b00, 32'h20, 32'h0);
    #1;
    check("idle_out_zero", DataMemOut, 32'h0);
    tick();

    // Word store then forwarded byte load, then array read.
    drive(2'b00, 2'b11, 32'h40, 32'h1234_5678); tick();
    drive(2'b01, 2'b00, 32'h43, 32'h0);
    @(negedge Clk);
    check("fwd_byte_43", DataMemOut, 32'h0000_0012);
    tick();
    drive(2'b00, 2'b00, 32'h0, 32'h0); tick(); tick();
    drive(2'b11, 2'b00, 32'h40, 32'h0);
    @(negedge Clk);
    check("array_word_40", DataMemOut, 32'h1234_5678);
    tick();

    // Byte store merged over an older word, half load sign-extends.
    drive(2'b00, 2'b11, 32'h40, 32'hAABB_CCDD); tick();
    check("stores_before_byte", StoreCount, 32'd2);
    drive(2'b00, 2'b01, 32'h41, 32'h0000_00F0); tick();
    drive(2'b10, 2'b00, 32'h40, 32'h0);
    @(negedge Clk);
    check("merge_half_40", DataMemOut, 32'hFFFF_F0DD);
    check("stores_after_byte", StoreCount, 32'd3);
    tick();
    drive(2'b01, 2'b00, 32'h42, 32'h0);
    @(negedge Clk);
    check("byte_42_sext", DataMemOut, 32'hFFFF_FFBB);
    tick();
    drive(2'b10, 2'b00, 32'h42, 32'h0);
    @(negedge Clk);
    check("half_42_sext", DataMemOut, 32'hFFFF_AABB);
    tick();

    // Misaligned word load, sticky first-error address, MMIO clear.
    drive(2'b11, 2'b00, 32'h42, 32'h0);
    @(negedge Clk);
    check("misalign_out_zero", DataMemOut, 32'h0);
    tick();
    check("misalign_flag", {31'b0, AlignErr}, 32'h1);
    check("misalign_addr", ErrAddr, 32'h42);
    drive(2'b00, 2'b10, 32'h11, 32'h0000_7777); tick();
    check("second_err_hold", ErrAddr, 32'h42);
    check("second_err_no_store", StoreCount, 32'd3);
    drive(2'b11, 2'b00, 32'hFFFF_0008, 32'h0);
    @(negedge Clk);
    check("mmio_status_set", DataMemOut, 32'h1);
    tick();
    drive(2'b00, 2'b11, 32'hFFFF_0008, 32'h0); tick();
    check("clear_flag", {31'b0, AlignErr}, 32'h0);
    check("clear_addr", ErrAddr, 32'h0);

    // MMIO counter reads and a store that must not count.
    drive(2'b11, 2'b00, 32'hFFFF_0000, 32'h0);
    @(negedge Clk);
    check("mmio_cycle", DataMemOut, k);
    tick();
    drive(2'b10, 2'b00, 32'hFFFF_0000, 32'h0);
    @(negedge Clk);
    check("mmio_cycle_half_full", DataMemOut, k);
    tick();
    drive(2'b00, 2'b11, 32'hFFFF_0004, 32'h9999_9999); tick();
    check("mmio_store_nocount", StoreCount, 32'd3);
    drive(2'b11, 2'b00, 32'hFFFF_0004, 32'h0);
    @(negedge Clk);
    check("mmio_stores_read", DataMemOut, 32'd3);
    check("cycle_port", CycleCount, k);
    tick();

    // Simultaneous load and store is rejected.
    drive(2'b00, 2'b11, 32'h80, 32'h0BAD_F00D); tick();
    drive(2'b00, 2'b00, 32'h0, 32'h0); tick(); tick();
    drive(2'b11, 2'b11, 32'h80, 32'h5555_5555);
    @(negedge Clk);
    check("conflict_out_zero", DataMemOut, 32'h0);
    tick();
    check("conflict_flag", {31'b0, AlignErr}, 32'h1);
    check("conflict_addr", ErrAddr, 32'h80);
    drive(2'b00, 2'b00, 32'h0, 32'h0); tick(); tick();
    drive(2'b11, 2'b00, 32'h80, 32'h0);
    @(negedge Clk);
    check("conflict_no_write", DataMemOut, 32'h0BAD_F00D);
    check("conflict_no_count", StoreCount, 32'd4);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
